// File: rtl/dram_burst_reader.sv
// Purpose : DRAM-side read engine feeding the interface-unit FIFO write port (wclk domain).
// Latency : dram_rvalid in cycle N gives valid_from_DRAM in cycle N+1 at the earliest.
// Backpres: wfull stalls the skid head; requests throttle once outstanding+buffered hits SKID_DEPTH.
//
// Ports:
//   wclk, reset (async, active-low)
//   start / base_address / length   transfer command (length 0 is a no-op with a done pulse)
//   busy, done                      status; done is a single-cycle pulse
//   dram_req / dram_addr / dram_gnt read request handshake
//   dram_rvalid / dram_rdata        in-order read responses, arbitrary latency >= 1
//   wfull                           FIFO full (back-pressure)
//   valid_from_DRAM / wdata_from_DRAM  FIFO write strobe and data
//   protocol_err                    sticky: response seen with nothing outstanding
//   stall_cycles                    only when STALL_CNT_EN is defined
//
// Optional feature macro: STALL_CNT_EN (adds the saturating stall_cycles counter and port).

module dram_burst_reader #(
  parameter int FIFO_WIDTH = 64,
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 16,
  parameter int SKID_DEPTH = 4,
  parameter int ADDR_STEP  = 1
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  dram_req,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic                  dram_gnt,
  input  logic                  dram_rvalid,
  input  logic [FIFO_WIDTH-1:0] dram_rdata,
  input  logic                  wfull,
  output logic                  valid_from_DRAM,
  output logic [FIFO_WIDTH-1:0] wdata_from_DRAM,
  output logic                  protocol_err
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;  // counter width, holds 0..SKID_DEPTH
  localparam int PW = $clog2(SKID_DEPTH);      // skid pointer width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         skid_count_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [FIFO_WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic                  perr_q;

  logic [CW:0]           credit_used;
  logic                  gnt_acc;
  logic                  rsp_acc;
  logic                  skid_empty;
  logic                  pop;

  // Words in flight plus words parked locally never exceed the buffer size,
  // so a response always has somewhere to land even with wfull held.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, skid_count_q};
  assign skid_empty  = (skid_count_q == '0);

  // Inside REQ, only a grant can raise credit_used (a response moves a word
  // from outstanding to the buffer, a pop lowers it), so a raised request
  // stays up with a stable address until it is granted.
  assign dram_req  = (state_q == S_REQ) && (credit_used < (CW + 1)'(SKID_DEPTH));
  assign dram_addr = addr_q;
  assign gnt_acc   = dram_req & dram_gnt;

  // A response with nothing outstanding is dropped rather than underflowing.
  assign rsp_acc   = dram_rvalid & (outstanding_q != '0);

  assign pop             = !skid_empty & !wfull;
  assign valid_from_DRAM = pop;
  assign wdata_from_DRAM = skid_mem[rd_ptr_q];

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign protocol_err = perr_q;

  // Control FSM with address and length tracking.
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_q      <= base_address;
              remaining_q <= length;
              state_q     <= S_REQ;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (gnt_acc) begin
            addr_q      <= addr_q + ADDR_WIDTH'(ADDR_STEP);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((outstanding_q == '0) && skid_empty) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outstanding-request counter; grant and response together net to zero.
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else begin
      case ({gnt_acc, rsp_acc})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Skid buffer: circular store, push on accepted response, pop on FIFO write.
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      skid_count_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_mem[i] <= '0;
      end
    end else begin
      if (rsp_acc) begin
        skid_mem[wr_ptr_q] <= dram_rdata;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({rsp_acc, pop})
        2'b10:   skid_count_q <= skid_count_q + CW'(1);
        2'b01:   skid_count_q <= skid_count_q - CW'(1);
        default: skid_count_q <= skid_count_q;
      endcase
    end
  end

  // Sticky protocol error: only reset clears it.
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (dram_rvalid && (outstanding_q == '0)) begin
      perr_q <= 1'b1;
    end
  end

`ifdef STALL_CNT_EN
  // Cycles where data is waiting but the FIFO refuses it; saturating,
  // restarted by each accepted command.
  logic [15:0] stall_q;

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if (!skid_empty && wfull && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dram_burst_reader.sv
// Purpose : stimulus, DRAM responder and scoreboard for dram_burst_reader.
// Latency : responder returns read data two cycles after each grant.
// Backpres: wfull driven directly by the stimulus sequence.

module tb_dram_burst_reader;

  localparam int FW = 64;
  localparam int AW = 20;
  localparam int LW = 16;

  logic          wclk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          dram_req;
  logic [AW-1:0] dram_addr;
  logic          dram_gnt;
  logic          dram_rvalid;
  logic [FW-1:0] dram_rdata;
  logic          wfull;
  logic          valid_from_DRAM;
  logic [FW-1:0] wdata_from_DRAM;
  logic          protocol_err;
`ifdef STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  always #5 wclk = ~wclk;

  dram_burst_reader #(
    .FIFO_WIDTH(FW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SKID_DEPTH(4), .ADDR_STEP(1)
  ) dut (
    .wclk(wclk),
    .reset(reset),
    .start(start),
    .base_address(base_address),
    .length(length),
    .busy(busy),
    .done(done),
    .dram_req(dram_req),
    .dram_addr(dram_addr),
    .dram_gnt(dram_gnt),
    .dram_rvalid(dram_rvalid),
    .dram_rdata(dram_rdata),
    .wfull(wfull),
    .valid_from_DRAM(valid_from_DRAM),
    .wdata_from_DRAM(wdata_from_DRAM),
    .protocol_err(protocol_err)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int            n_checks  = 0;
  int            n_fail    = 0;
  int            cyc       = 0;
  int            grant_cnt = 0;
  logic          inject_rv = 1'b0;
  logic [AW-1:0] exp_addr_q [$];
  logic [FW-1:0] exp_data_q [$];
  int            due_q      [$];
  logic [FW-1:0] rsp_q      [$];

  function automatic logic [FW-1:0] dat(input logic [AW-1:0] a);
    return {12'hD00, a, 12'h5A5, a};
  endfunction

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic expect_words(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(dat(a));
    end
  endtask

  task automatic issue(input logic [AW-1:0] base, input logic [LW-1:0] len);
    start        = 1'b1;
    base_address = base;
    length       = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    tick();
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_req"}, 64'(dram_req), 64'd0);
    check({name, "_addr"}, 64'(dram_addr), 64'd0);
    check({name, "_valid"}, 64'(valid_from_DRAM), 64'd0);
    check({name, "_wdata"}, wdata_from_DRAM, 64'd0);
    check({name, "_perr"}, 64'(protocol_err), 64'd0);
`ifdef STALL_CNT_EN
    check({name, "_stall"}, 64'(stall_cycles), 64'd0);
`endif
  endtask

  // DRAM responder: records grants at mid-cycle, returns data two cycles later.
  initial begin
    dram_rvalid = 1'b0;
    dram_rdata  = '0;
    forever begin
      @(negedge wclk);
      cyc++;
      if (!reset) begin
        due_q.delete();
        rsp_q.delete();
      end else if (dram_req && dram_gnt) begin
        grant_cnt++;
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_addr: actual=%0h required=no grant", dram_addr);
        end else begin
          check("grant_addr", 64'(dram_addr), 64'(exp_addr_q.pop_front()));
        end
        due_q.push_back(cyc + 2);
        rsp_q.push_back(dat(dram_addr));
      end
      @(posedge wclk);
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        dram_rvalid = 1'b1;
        dram_rdata  = rsp_q.pop_front();
        void'(due_q.pop_front());
      end else if (inject_rv) begin
        dram_rvalid = 1'b1;
        dram_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        inject_rv   = 1'b0;
      end else begin
        dram_rvalid = 1'b0;
        dram_rdata  = '0;
      end
    end
  end

  // FIFO-side monitor: every strobe must match the next expected word.
  initial begin
    forever begin
      @(negedge wclk);
      if (reset && valid_from_DRAM) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fifo_data: actual=%0h required=no strobe", wdata_from_DRAM);
        end else begin
          check("fifo_data", wdata_from_DRAM, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0;
    int n;
    reset        = 1'b0;
    start        = 1'b0;
    base_address = '0;
    length       = '0;
    dram_gnt     = 1'b0;
    wfull        = 1'b0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    reset    = 1'b1;
    dram_gnt = 1'b1;
    tick();

    // 1: eight words from 0x100, free-flowing FIFO; a second start while busy is ignored
    expect_words(20'h00100, 8);
    g0 = grant_cnt;
    issue(20'h00100, 16'd8);
    check("t1_busy", 64'(busy), 64'd1);
    start        = 1'b1;
    base_address = 20'h00999;
    length       = 16'd3;
    tick();
    start = 1'b0;
    wait_done("t1", 200);
    check("t1_grants", 64'(grant_cnt - g0), 64'd8);
    check("t1_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    check("t1_data_q_empty", 64'(exp_data_q.size()), 64'd0);

    // 2: six words against a full FIFO, credit caps grants at 4
    wfull = 1'b1;
    expect_words(20'h00040, 6);
    g0 = grant_cnt;
    issue(20'h00040, 16'd6);
    for (int i = 0; i < 20; i++) tick();
    check("t2_grants_capped", 64'(grant_cnt - g0), 64'd4);
    check("t2_req_low", 64'(dram_req), 64'd0);
    check("t2_no_strobe", 64'(valid_from_DRAM), 64'd0);
    check("t2_data_held", 64'(exp_data_q.size()), 64'd6);
    wfull = 1'b0;
    wait_done("t2", 200);
    check("t2_grants_total", 64'(grant_cnt - g0), 64'd6);
    check("t2_data_q_empty", 64'(exp_data_q.size()), 64'd0);

    // 3: zero-length command
    g0 = grant_cnt;
    issue(20'h00300, 16'd0);
    check("t3_done_next", 64'(done), 64'd1);
    check("t3_no_req", 64'(dram_req), 64'd0);
    tick();
    check("t3_done_once", 64'(done), 64'd0);
    check("t3_idle", 64'(busy), 64'd0);
    check("t3_no_grants", 64'(grant_cnt - g0), 64'd0);

    // 4: address wrap at the top of the DRAM space
    exp_addr_q.push_back(20'hFFFFE); exp_data_q.push_back(dat(20'hFFFFE));
    exp_addr_q.push_back(20'hFFFFF); exp_data_q.push_back(dat(20'hFFFFF));
    exp_addr_q.push_back(20'h00000); exp_data_q.push_back(dat(20'h00000));
    exp_addr_q.push_back(20'h00001); exp_data_q.push_back(dat(20'h00001));
    issue(20'hFFFFE, 16'd4);
    wait_done("t4", 200);
    check("t4_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    check("t4_data_q_empty", 64'(exp_data_q.size()), 64'd0);

`ifdef STALL_CNT_EN
    // 6: stall counter over ten data-pending cycles
    wfull = 1'b1;
    expect_words(20'h00500, 6);
    issue(20'h00500, 16'd6);
    for (int i = 0; i < 13; i++) tick();
    wfull = 1'b0;
    check("t6_stall_at_release", 64'(stall_cycles), 64'd10);
    wait_done("t6", 200);
    check("t6_stall_final", 64'(stall_cycles), 64'd10);
    check("t6_data_q_empty", 64'(exp_data_q.size()), 64'd0);
`endif

    // 5a: stray response while idle
    inject_rv = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t5_perr_set", 64'(protocol_err), 64'd1);
    check("t5_no_strobe", 64'(valid_from_DRAM), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_perr_sticky", 64'(protocol_err), 64'd1);

    // 5b: reset after three grants of an eight-word transfer
    wfull = 1'b1;
    expect_words(20'h00200, 8);
    g0 = grant_cnt;
    issue(20'h00200, 16'd8);
    n = 0;
    while ((grant_cnt - g0) < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t5_three_grants", 64'(grant_cnt - g0), 64'd3);
    reset = 1'b0;
    tick();
    check_all_zero("t5_reset");
    exp_addr_q.delete();
    exp_data_q.delete();
    reset = 1'b1;
    wfull = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_idle_after", 64'(busy), 64'd0);
    check("t5_req_after", 64'(dram_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
